fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
- Parametrised address and control sequencer for an in-place radix-2 DIT FFT of N = 2^LOG2N points.
- Steps through all LOG2N stages and N/2 butterflies per stage, one butterfly issued per enabled cycle.
- Generates read addresses, twiddle address, per-stage select and delayed write strobes.
- Inserts a pipeline flush between stages so no read overtakes an outstanding write.
- Sits between the top-level start/done handshake and the butterfly datapath and sample RAM.

Parameters:
LOG2N, 4, log2 of FFT length; legal 2..10.
PIPE_LAT, 2, butterfly datapath latency in cycles from read issue to write-back; legal 0..7.
SW, derived = max(1, clog2(LOG2N)), stage index width (localparam).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  start request; sampled only in IDLE
i_en  in  1  issue enable; 0 stalls butterfly issue in RUN
o_busy  out  1  high in RUN and FLUSH
o_stage  out  SW  current stage index 0..LOG2N-1
o_mux_sel  out  2  o_stage[1:0]; zero-extended when SW=1
o_valid  out  1  read issue strobe for o_addr_a/o_addr_b/o_tw_addr
o_addr_a  out  LOG2N  upper-leg sample address
o_addr_b  out  LOG2N  lower-leg sample address
o_tw_addr  out  LOG2N-1  twiddle ROM address
o_wr_en  out  1  o_valid delayed PIPE_LAT cycles
o_wr_addr_a  out  LOG2N  o_addr_a delayed PIPE_LAT cycles
o_wr_addr_b  out  LOG2N  o_addr_b delayed PIPE_LAT cycles
o_stage_done  out  1  one-cycle pulse on the last FLUSH cycle of each stage (last issue cycle if PIPE_LAT=0)
o_done  out  1  one-cycle pulse at FFT completion

Behaviour:
- States: IDLE, RUN, FLUSH, DONE. i_rst forces IDLE regardless of state, including mid-FFT.
- On reset, all outputs are 0 and the stage and butterfly counters are 0. The write delay line is also cleared, so no pending o_wr_en survives reset.
- IDLE: if i_start=1, go to RUN next cycle with stage=0, k=0. All other inputs are ignored.
- RUN: if i_en=1, assert o_valid with addresses for (stage, k) in the same cycle, then advance k.
  - If i_en=0, o_valid=0 and the counters hold.
  - When k = N/2-1 is issued, go to FLUSH if PIPE_LAT>0.
  - Otherwise the stage advances directly (PIPE_LAT=0).
- FLUSH: lasts exactly PIPE_LAT cycles, independent of i_en.
  - On its last cycle, pulse o_stage_done.
  - If stage < LOG2N-1, increment stage, clear k and go to RUN.
  - Otherwise go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE. i_start in DONE is ignored.
- i_start while busy is ignored and must not restart the sequence.
- Address rules, with s=stage, k=0..N/2-1, pos = k mod 2^s:
  - o_addr_a = ((k>>s)<<(s+1)) | pos
  - o_addr_b = o_addr_a + 2^s
  - o_tw_addr = pos << (LOG2N-1-s)
- Addresses are combinational from the registered counters. o_addr_* are don't-care when o_valid=0.
- The write delay line is a PIPE_LAT-deep shift register. It advances every cycle and is not stalled by i_en.
- o_stage and o_mux_sel hold their value through FLUSH and update on entry to the next RUN.
- After DONE they return to 0 in IDLE.
- Counter wrap: k is LOG2N-1 bits and wraps to 0 only at a stage change. Stage never exceeds LOG2N-1.

Test Plan:
- Defaults (LOG2N=4, PIPE_LAT=2), i_en=1, i_start pulsed at cycle 0:
  - o_busy high cycles 1..40; o_valid high cycles 1-8, 11-18, 21-28 and 31-38.
  - o_stage_done at cycles 10, 20, 30 and 40; o_done=1 at cycle 41 only.
- Address check at stage 2 (s=2):
  - k=0 -> a=0, b=4, tw=0.
  - k=5 -> a=9, b=13, tw=2.
  - All 32 issued (a,b) pairs cover each address exactly once per stage.
- Write timing: every o_valid at cycle t is matched by o_wr_en at t+2 with identical addresses. No o_valid occurs in the cycle of, or before, the last o_wr_en of the prior stage.
- Stall: i_en=0 for 3 cycles after 4 issues in stage 0.
  - Counters hold; o_valid=0 for those 3 cycles.
  - Completion shifts by exactly 3 cycles; o_done at cycle 44.
- Reset at cycle 15, mid-stage 1: the next cycle shows IDLE with all outputs 0 and o_wr_en=0. A new i_start reruns the full 41-cycle sequence.
- LOG2N=3, PIPE_LAT=0:
  - Stages 0-2 each run 4 issues back to back; o_valid is continuous over cycles 1..12.
  - o_done at cycle 13; i_start pulses during busy are ignored.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sequencer
// Purpose  : Stage/butterfly address sequencer for an in-place radix-2 DIT FFT
//            with inter-stage pipeline flush and delayed write strobes.
// Revision : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer #(
    parameter  int LOG2N    = 4,
    parameter  int PIPE_LAT = 2,
    localparam int SW       = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_en,
    output logic               o_busy,
    output logic [SW-1:0]      o_stage,
    output logic [1:0]         o_mux_sel,
    output logic               o_valid,
    output logic [LOG2N-1:0]   o_addr_a,
    output logic [LOG2N-1:0]   o_addr_b,
    output logic [LOG2N-2:0]   o_tw_addr,
    output logic               o_wr_en,
    output logic [LOG2N-1:0]   o_wr_addr_a,
    output logic [LOG2N-1:0]   o_wr_addr_b,
    output logic               o_stage_done,
    output logic               o_done
);

    localparam int            KW           = LOG2N - 1;
    localparam logic [SW-1:0] C_LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [KW-1:0] C_LAST_K     = '1;
    localparam logic [2:0]    C_LAST_FLUSH = 3'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [KW-1:0]   k_q, k_d;
    logic [2:0]      flush_q, flush_d;
    logic            w_valid;
    logic            w_stage_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        k_d          = k_q;
        flush_d      = flush_q;
        w_valid      = 1'b0;
        w_stage_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    k_d     = '0;
                    flush_d = '0;
                end
            end
            ST_RUN: begin
                if (i_en) begin
                    w_valid = 1'b1;
                    if (k_q == C_LAST_K) begin
                        k_d = '0;
                        if (PIPE_LAT > 0) begin
                            state_d = ST_FLUSH;
                            flush_d = '0;
                        end else begin
                            // No datapath latency: the stage ends on its last issue.
                            w_stage_done = 1'b1;
                            if (stage_q == C_LAST_STAGE) begin
                                state_d = ST_DONE;
                            end else begin
                                stage_d = stage_q + SW'(1);
                            end
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_q == C_LAST_FLUSH) begin
                    w_stage_done = 1'b1;
                    if (stage_q == C_LAST_STAGE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    flush_d = flush_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stage_d = '0;
                k_d     = '0;
            end
        endcase
    end

    // Butterfly span is 2^s: the low s bits of k select the position inside a
    // group, the remaining bits select the group (shifted past the span bit).
    logic [KW-1:0]    w_mask;
    logic [KW-1:0]    w_pos;
    logic [LOG2N-1:0] w_addr_a;
    logic [LOG2N-1:0] w_addr_b;
    logic [SW-1:0]    w_tw_shift;
    logic             w_run;

    always_comb begin
        w_mask     = (KW'(1) << stage_q) - KW'(1);
        w_pos      = k_q & w_mask;
        w_addr_a   = {k_q & ~w_mask, 1'b0} | {1'b0, w_pos};
        w_addr_b   = w_addr_a + (LOG2N'(1) << stage_q);
        w_tw_shift = C_LAST_STAGE - stage_q;
    end

    assign w_run        = (state_q == ST_RUN);
    assign o_addr_a     = w_run ? w_addr_a : '0;
    assign o_addr_b     = w_run ? w_addr_b : '0;
    assign o_tw_addr    = w_run ? (w_pos << w_tw_shift) : '0;
    assign o_valid      = w_valid;
    assign o_busy       = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign o_done       = (state_q == ST_DONE);
    assign o_stage      = stage_q;
    assign o_stage_done = w_stage_done;

    generate
        if (SW >= 2) begin : g_mux_wide
            assign o_mux_sel = stage_q[1:0];
        end else begin : g_mux_narrow
            assign o_mux_sel = {1'b0, stage_q};
        end
    endgenerate

    generate
        if (PIPE_LAT > 0) begin : g_wr_delay
            logic [PIPE_LAT-1:0] wr_en_q;
            logic [LOG2N-1:0]    wr_a_q [PIPE_LAT];
            logic [LOG2N-1:0]    wr_b_q [PIPE_LAT];

            // Free-running: the write-back timing follows the datapath, not i_en.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    wr_en_q <= '0;
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        wr_a_q[i] <= '0;
                        wr_b_q[i] <= '0;
                    end
                end else begin
                    wr_en_q[0] <= w_valid;
                    wr_a_q[0]  <= o_addr_a;
                    wr_b_q[0]  <= o_addr_b;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        wr_en_q[i] <= wr_en_q[i-1];
                        wr_a_q[i]  <= wr_a_q[i-1];
                        wr_b_q[i]  <= wr_b_q[i-1];
                    end
                end
            end

            assign o_wr_en     = wr_en_q[PIPE_LAT-1];
            assign o_wr_addr_a = wr_a_q[PIPE_LAT-1];
            assign o_wr_addr_b = wr_b_q[PIPE_LAT-1];
        end else begin : g_wr_pass
            assign o_wr_en     = w_valid;
            assign o_wr_addr_a = o_addr_a;
            assign o_wr_addr_b = o_addr_b;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_stage_sequencer
// Purpose  : Self-checking bench: timeline reference model plus directed and
//            randomized runs on a (4,2) and a (3,0) sequencer instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_stage_sequencer;

    localparam int HIST = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_a = 1'b0, en_a = 1'b0, start_b = 1'b0, en_b = 1'b0;

    logic       busy_a, valid_a, wr_a, sd_a, done_a;
    logic [1:0] stage_a, mux_a;
    logic [3:0] a_a, b_a, wa_a, wb_a;
    logic [2:0] tw_a;

    logic       busy_b, valid_b, wr_b, sd_b, done_b;
    logic [1:0] stage_b, mux_b;
    logic [2:0] a_b, b_b, wa_b, wb_b;
    logic [1:0] tw_b;

    fft_stage_sequencer #(.LOG2N(4), .PIPE_LAT(2)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_en(en_a),
        .o_busy(busy_a), .o_stage(stage_a), .o_mux_sel(mux_a), .o_valid(valid_a),
        .o_addr_a(a_a), .o_addr_b(b_a), .o_tw_addr(tw_a), .o_wr_en(wr_a),
        .o_wr_addr_a(wa_a), .o_wr_addr_b(wb_a), .o_stage_done(sd_a), .o_done(done_a)
    );

    fft_stage_sequencer #(.LOG2N(3), .PIPE_LAT(0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_en(en_b),
        .o_busy(busy_b), .o_stage(stage_b), .o_mux_sel(mux_b), .o_valid(valid_b),
        .o_addr_a(a_b), .o_addr_b(b_b), .o_tw_addr(tw_b), .o_wr_en(wr_b),
        .o_wr_addr_a(wa_b), .o_wr_addr_b(wb_b), .o_stage_done(sd_b), .o_done(done_b)
    );

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    bit  model_on = 1'b0;
    int  pos [2] = '{-1, -1};
    int  last_rst [2] = '{-1000, -1000};
    int  t0 [2] = '{-1000, -1000};
    bit  done_seen [2];
    bit  hv [2][HIST];
    int  ha [2][HIST];
    int  hb [2][HIST];

    logic        rec_valid [2][64];
    logic        rec_busy  [2][64];
    logic        rec_sd    [2][64];
    logic        rec_done  [2][64];
    logic        rec_wr    [2][64];
    logic [31:0] rec_a     [2][64];
    logic [31:0] rec_b     [2][64];
    logic [31:0] rec_tw    [2][64];
    logic [31:0] rec_stage [2][64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int u, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL u%0d %s at cycle %0d: got 0x%0h, want 0x%0h", u, nm, cyc, act, exp);
        end
    endtask

    // The run is a timeline of LOG2N slots of (N/2 issues + PIPE_LAT flush
    // cycles) followed by one done slot; issue slots advance only when enabled.
    task automatic model_step(
        input int u, input int lg, input int pl,
        input logic r, input logic st_in, input logic en,
        input logic busy, input logic [31:0] stage, input logic [31:0] mux,
        input logic valid, input logic [31:0] a, input logic [31:0] b, input logic [31:0] tw,
        input logic wr, input logic [31:0] wa, input logic [31:0] wb,
        input logic sd, input logic done);
        int half, slot, donej, p, s, w, k, t, rel;
        int e_valid, e_sd, e_busy, e_done, e_stage, ea, eb, etw, e_wr;
        half = 1 << (lg - 1);
        slot = half + pl;
        donej = lg * slot;
        p = pos[u];
        t = cyc;
        e_valid = 0; e_sd = 0; e_busy = 0; e_done = 0; e_stage = 0;
        ea = 0; eb = 0; etw = 0; w = 0;
        if (p == donej) begin
            e_done = 1;
        end else if (p >= 0) begin
            s = p / slot;
            w = p % slot;
            e_busy = 1;
            e_stage = s;
            if (w < half) begin
                k = w;
                e_valid = en ? 1 : 0;
                ea = (k / (1 << s)) * (1 << (s + 1)) + (k % (1 << s));
                eb = ea + (1 << s);
                etw = (k % (1 << s)) * (1 << (lg - 1 - s));
                e_sd = (en && (w == slot - 1)) ? 1 : 0;
            end else begin
                e_sd = (w == slot - 1) ? 1 : 0;
            end
        end
        chk(u, "busy", 64'(busy), 64'(e_busy));
        chk(u, "valid", 64'(valid), 64'(e_valid));
        chk(u, "stage_done", 64'(sd), 64'(e_sd));
        chk(u, "done", 64'(done), 64'(e_done));
        if (p != donej) begin
            chk(u, "stage", 64'(stage), 64'(e_stage));
            chk(u, "mux_sel", 64'(mux), 64'(e_stage % 4));
        end
        if (e_valid != 0) begin
            chk(u, "addr_a", 64'(a), 64'(ea));
            chk(u, "addr_b", 64'(b), 64'(eb));
            chk(u, "tw_addr", 64'(tw), 64'(etw));
        end
        hv[u][t % HIST] = (e_valid != 0);
        ha[u][t % HIST] = ea;
        hb[u][t % HIST] = eb;
        e_wr = 0;
        if (t - pl >= 0 && t - pl > last_rst[u]) e_wr = hv[u][(t - pl) % HIST] ? 1 : 0;
        chk(u, "wr_en", 64'(wr), 64'(e_wr));
        if (e_wr != 0) begin
            chk(u, "wr_addr_a", 64'(wa), 64'(ha[u][(t - pl) % HIST]));
            chk(u, "wr_addr_b", 64'(wb), 64'(hb[u][(t - pl) % HIST]));
        end
        rel = t - t0[u];
        if (rel >= 0 && rel < 64) begin
            rec_valid[u][rel] = valid; rec_busy[u][rel] = busy; rec_sd[u][rel] = sd;
            rec_done[u][rel] = done;   rec_wr[u][rel] = wr;     rec_a[u][rel] = a;
            rec_b[u][rel] = b;         rec_tw[u][rel] = tw;     rec_stage[u][rel] = stage;
        end
        if (done === 1'b1) done_seen[u] = 1'b1;
        if (r) begin
            pos[u] = -1;
            last_rst[u] = t;
        end else if (p < 0) begin
            if (st_in) pos[u] = 0;
        end else if (p == donej) begin
            pos[u] = -1;
        end else if (w >= half || en) begin
            pos[u] = p + 1;
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            model_step(0, 4, 2, rst, start_a, en_a, busy_a, 32'(stage_a), 32'(mux_a), valid_a,
                       32'(a_a), 32'(b_a), 32'(tw_a), wr_a, 32'(wa_a), 32'(wb_a), sd_a, done_a);
            model_step(1, 3, 0, rst, start_b, en_b, busy_b, 32'(stage_b), 32'(mux_b), valid_b,
                       32'(a_b), 32'(b_b), 32'(tw_b), wr_b, 32'(wa_b), 32'(wb_b), sd_b, done_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test(input int u);
        for (int r = 0; r < 64; r++) begin
            rec_valid[u][r] = 1'b0; rec_busy[u][r] = 1'b0; rec_sd[u][r] = 1'b0;
            rec_done[u][r] = 1'b0;  rec_wr[u][r] = 1'b0;   rec_a[u][r] = '0;
            rec_b[u][r] = '0;       rec_tw[u][r] = '0;     rec_stage[u][r] = '0;
        end
        t0[u] = cyc;
    endtask

    function automatic logic [63:0] pat(input int u, input int which);
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < 64; r++) begin
            case (which)
                0:       v[r] = rec_valid[u][r];
                1:       v[r] = rec_busy[u][r];
                2:       v[r] = rec_sd[u][r];
                3:       v[r] = rec_done[u][r];
                default: v[r] = rec_wr[u][r];
            endcase
        end
        return v;
    endfunction

    task automatic run_random(input int u, input int runs);
        for (int r = 0; r < runs; r++) begin
            int guard;
            int rc;
            done_seen[u] = 1'b0;
            if (u == 0) start_a = 1'b1; else start_b = 1'b1;
            tick();
            rc = (r == 2) ? int'($urandom_range(5, 40)) : -10;
            guard = 0;
            while (!done_seen[u] && guard < 600) begin
                logic e, s;
                e = ($urandom_range(0, 3) != 0);
                s = ($urandom_range(0, 7) == 0) || (guard == rc + 1);
                rst = (guard == rc);
                if (u == 0) begin en_a = e; start_a = s; end
                else begin en_b = e; start_b = s; end
                tick();
                guard++;
            end
            rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
            chk(u, "rand_done_seen", 64'(done_seen[u]), 64'd1);
            tick(); tick();
        end
    endtask

    initial begin
        logic [63:0] ev;
        int cnt [16];
        logic [15:0] okm;

        tick();
        model_on = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk(0, "reset_busy", 64'(busy_a), 64'd0);
        chk(0, "reset_wr_en", 64'(wr_a), 64'd0);

        // Uninterrupted run, LOG2N=4 PIPE_LAT=2
        begin_test(0);
        start_a = 1'b1; en_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (46) tick();
        ev = '0;
        for (int s = 0; s < 4; s++) for (int k = 0; k < 8; k++) ev[10*s + 1 + k] = 1'b1;
        chk(0, "t1_valid_pattern", pat(0, 0), ev);
        chk(0, "t1_wr_pattern", pat(0, 4), ev << 2);
        ev = '0;
        for (int r = 1; r <= 40; r++) ev[r] = 1'b1;
        chk(0, "t1_busy_pattern", pat(0, 1), ev);
        ev = '0; ev[10] = 1'b1; ev[20] = 1'b1; ev[30] = 1'b1; ev[40] = 1'b1;
        chk(0, "t1_stage_done_pattern", pat(0, 2), ev);
        ev = '0; ev[41] = 1'b1;
        chk(0, "t1_done_pattern", pat(0, 3), ev);
        chk(0, "s2k0_a", 64'(rec_a[0][21]), 64'd0);
        chk(0, "s2k0_b", 64'(rec_b[0][21]), 64'd4);
        chk(0, "s2k0_tw", 64'(rec_tw[0][21]), 64'd0);
        chk(0, "s2k5_a", 64'(rec_a[0][26]), 64'd9);
        chk(0, "s2k5_b", 64'(rec_b[0][26]), 64'd13);
        chk(0, "s2k5_tw", 64'(rec_tw[0][26]), 64'd2);
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 16; i++) cnt[i] = 0;
            for (int r = 10*s + 1; r <= 10*s + 8; r++) begin
                if (rec_a[0][r] < 16) cnt[rec_a[0][r]]++;
                if (rec_b[0][r] < 16) cnt[rec_b[0][r]]++;
            end
            for (int i = 0; i < 16; i++) okm[i] = (cnt[i] == 1);
            chk(0, $sformatf("cover_stage%0d", s), 64'(okm), 64'hFFFF);
        end

        // Three-cycle stall after four issues in stage 0
        begin_test(0);
        start_a = 1'b1; en_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        en_a = 1'b0;
        repeat (3) tick();
        en_a = 1'b1;
        repeat (40) tick();
        ev = '0;
        for (int k = 0; k < 4; k++) ev[1 + k] = 1'b1;
        for (int k = 4; k < 8; k++) ev[4 + k] = 1'b1;
        for (int s = 1; s < 4; s++) for (int k = 0; k < 8; k++) ev[14 + 10*(s-1) + k] = 1'b1;
        chk(0, "t2_valid_pattern", pat(0, 0), ev);
        ev = '0; ev[44] = 1'b1;
        chk(0, "t2_done_pattern", pat(0, 3), ev);
        chk(0, "t2_k4_a", 64'(rec_a[0][8]), 64'd8);
        chk(0, "t2_k4_b", 64'(rec_b[0][8]), 64'd9);

        // Reset in the middle of stage 1, then a full rerun
        begin_test(0);
        start_a = 1'b1; en_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk(0, "t3_busy_after_rst", 64'(rec_busy[0][16]), 64'd0);
        chk(0, "t3_valid_after_rst", 64'(rec_valid[0][16]), 64'd0);
        chk(0, "t3_wr_after_rst", 64'(rec_wr[0][16]), 64'd0);
        chk(0, "t3_wr2_after_rst", 64'(rec_wr[0][17]), 64'd0);
        chk(0, "t3_stage_after_rst", 64'(rec_stage[0][16]), 64'd0);
        begin_test(0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (46) tick();
        ev = '0; ev[41] = 1'b1;
        chk(0, "t3_rerun_done", pat(0, 3), ev);

        // LOG2N=3, PIPE_LAT=0 with start pulses while busy
        begin_test(1);
        start_b = 1'b1; en_b = 1'b1;
        for (int r = 1; r <= 20; r++) begin
            tick();
            start_b = (r == 3 || r == 7 || r == 12);
        end
        tick();
        chk(1, "t5_valid_pattern", pat(1, 0), 64'h1FFE);
        chk(1, "t5_busy_pattern", pat(1, 1), 64'h1FFE);
        chk(1, "t5_wr_pattern", pat(1, 4), 64'h1FFE);
        chk(1, "t5_stage_done_pattern", pat(1, 2), 64'h1110);
        chk(1, "t5_done_pattern", pat(1, 3), 64'h2000);

        run_random(0, 6);
        run_random(1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
